bounce_generator: RTL

- Synthesizable contact-bounce emulator; the transmit-side counterpart of the debouncing block.
- Takes a clean target level. On each change it drives sig_out through a burst of pseudo-random glitches, then settles on the new level.
- Used in FPGA self-test and simulation to stimulate the debouncing block without a physical switch.

---
 rtl/bounce_generator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: on each change of the clean target level, drives a burst of
// LFSR-timed glitches on o_sig_out before settling on the new level.
module bounce_generator #(
    parameter int unsigned BOUNCE_CNT = 4,
    parameter int unsigned DWELL_W    = 3,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level_in,
    input  logic i_en,
    output logic o_sig_out,
    output logic o_busy,
    output logic o_done
);

    localparam int unsigned TOG_W = (BOUNCE_CNT == 0) ? 1 : $clog2(2 * BOUNCE_CNT + 1);
    localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [TOG_W-1:0] TOG_INIT = TOG_W'(2 * BOUNCE_CNT);

    typedef enum logic {
        StStable = 1'b0,
        StBounce = 1'b1
    } state_e;

    state_e r_state, w_state_next;

    logic               r_target, w_target_next;
    logic               r_sig, w_sig_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;
    logic [7:0]         r_lfsr, w_lfsr_next;
    logic [DWELL_W:0]   r_dwell, w_dwell_next;
    logic [TOG_W-1:0]   r_toggles, w_toggles_next;

    logic [DWELL_W:0]   w_load;
    logic [7:0]         w_lfsr_step;
    logic               w_dwell_end;

    // Dwell is drawn from the pre-step LFSR value, range 1..2^DWELL_W.
    assign w_load      = (DWELL_W + 1)'(r_lfsr[DWELL_W-1:0]) + (DWELL_W + 1)'(1);
    assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[6] ^ r_lfsr[5] ^ r_lfsr[4]};
    assign w_dwell_end = (r_dwell == (DWELL_W + 1)'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StStable;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_target  <= 1'b0;
            r_sig     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lfsr    <= LFSR_INIT;
            r_dwell   <= '0;
            r_toggles <= '0;
        end else begin
            r_target  <= w_target_next;
            r_sig     <= w_sig_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_lfsr    <= w_lfsr_next;
            r_dwell   <= w_dwell_next;
            r_toggles <= w_toggles_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StStable: begin
                if ((i_level_in != r_target) && i_en) begin
                    w_state_next = StBounce;
                end
            end
            StBounce: begin
                if (w_dwell_end && (r_toggles == '0)) begin
                    w_state_next = StStable;
                end
            end
            default: w_state_next = StStable;
        endcase
    end

    always_comb begin
        w_target_next  = r_target;
        w_sig_next     = r_sig;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_lfsr_next    = r_lfsr;
        w_dwell_next   = r_dwell;
        w_toggles_next = r_toggles;
        unique case (r_state)
            StStable: begin
                w_busy_next = 1'b0;
                if (i_level_in != r_target) begin
                    w_target_next = i_level_in;
                    w_sig_next    = i_level_in;
                    if (i_en) begin
                        w_dwell_next   = w_load;
                        w_lfsr_next    = w_lfsr_step;
                        w_toggles_next = TOG_INIT;
                        w_busy_next    = 1'b1;
                    end
                end
            end
            StBounce: begin
                // Inputs are ignored here; a lasting difference is re-evaluated in StStable.
                if (!w_dwell_end) begin
                    w_dwell_next = r_dwell - (DWELL_W + 1)'(1);
                end else if (r_toggles != '0) begin
                    w_sig_next     = ~r_sig;
                    w_toggles_next = r_toggles - TOG_W'(1);
                    w_dwell_next   = w_load;
                    w_lfsr_next    = w_lfsr_step;
                end else begin
                    w_busy_next = 1'b0;
                    w_done_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_sig_out = r_sig;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule
